// File: rtl/conv_pkg.sv
// conv_pkg: shared states and defaults for the conv2d MAC sequencer
package conv_pkg;
  typedef enum logic [2:0] {CLEAR, BIAS, ACCUM, WAIT, CAPT, OUT} state_t;
  localparam int TAPS_DEF = 9;
  localparam int DW_DEF = 8;
  localparam int ACCW_DEF = 22;
  localparam int SAT_HI = 20;
  localparam int SAT_LO = 15;
endpackage

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: feeds one conv window per transaction into the signed MAC and returns its result
// Define CONV_SEQ_BIAS_EN to add a leading bias beat (only_add) to each window.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_pixel,
  input  logic [DW-1:0]   in_weight,
  output logic            mac_clr_n,
  output logic            mac_enable,
  output logic            mac_only_add,
  output logic [DW-1:0]   mac_din_a,
  output logic [DW-1:0]   mac_din_b,
  input  logic [DW-1:0]   mac_dout,
  input  logic [ACCW-1:0] mac_acc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_sat
);
`ifdef CONV_SEQ_BIAS_EN
  localparam state_t FIRST = BIAS;
`else
  localparam state_t FIRST = ACCUM;
`endif
  state_t state, state_nxt;
  logic [7:0] tap_cnt;
  logic hs, last, unused;
  assign in_ready = state == BIAS || state == ACCUM;
  assign hs = in_valid && in_ready;
  assign last = tap_cnt == 8'(TAPS - 1);
  assign mac_clr_n = state != CLEAR;
  assign unused = ^mac_acc[SAT_LO-1:0];
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: state_nxt = FIRST;
      BIAS:  state_nxt = hs ? ACCUM : BIAS;
      ACCUM: state_nxt = hs && last ? WAIT : ACCUM;
      WAIT:  state_nxt = CAPT;
      CAPT:  state_nxt = OUT;
      OUT:   state_nxt = out_ready ? CLEAR : OUT;
      default: state_nxt = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= CLEAR;
      tap_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      mac_enable <= 1'b0;
      mac_only_add <= 1'b0;
      mac_din_a <= '0;
      mac_din_b <= '0;
    end else begin
      state <= state_nxt;
      mac_enable <= hs;
      if (hs) begin
        mac_din_a <= in_pixel;
        mac_din_b <= state == ACCUM ? in_weight : mac_din_b;
`ifdef CONV_SEQ_BIAS_EN
        mac_only_add <= state == BIAS;
`endif
      end
      if (hs && state == ACCUM) tap_cnt <= last ? '0 : tap_cnt + 8'd1;
      // positive accumulators with bits above the 8-bit output field are flagged
      if (state == CAPT) begin
        out_data <= mac_dout;
        out_valid <= 1'b1;
        out_sat <= !mac_acc[ACCW-1] && |mac_acc[SAT_HI:SAT_LO];
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/conv_mac_seq.md
Name: conv_mac_seq

Overview:
- Upstream sequencer for the 8-bit signed MAC stage in the conv2d datapath.
- Accepts one convolution window per transaction as a valid/ready stream: an optional bias beat, then TAPS pixel/weight beats.
- Drives the MAC's clear, enable, only_add and operand inputs, then captures the MAC's quantized 8-bit ReLU output and 22-bit accumulator.
- Presents one result per window on a valid/ready output stream, with a saturation flag.

Parameters:
- TAPS, 9, number of pixel*weight products per window (3x3 kernel); legal range 1..255.
- DW, 8, operand and result width.
- ACCW, 22, MAC accumulator width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  window beat valid
- in_ready  out  1  sequencer accepts beat
- in_pixel  in  DW  signed pixel; carries the bias value on the bias beat
- in_weight  in  DW  signed weight; ignored on the bias beat
- mac_clr_n  out  1  to MAC rstn; low clears the accumulator
- mac_enable  out  1  to MAC enable
- mac_only_add  out  1  to MAC only_add
- mac_din_a  out  DW  to MAC din_a
- mac_din_b  out  DW  to MAC din_b
- mac_dout  in  DW  from MAC dout
- mac_acc  in  ACCW  from MAC acc_out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  captured mac_dout
- out_sat  out  1  positive accumulator exceeded the 8-bit representable range

Behaviour:
- Reset (rstn=0 at a clk edge): state=CLEAR, tap_cnt=0, out_valid=0, out_data=0, out_sat=0, mac_enable=0, mac_only_add=0, mac_din_a=0, mac_din_b=0. A reset mid-window abandons the window; no output is produced for it.
- mac_clr_n = 0 exactly while state==CLEAR, else 1. It is decoded from registered state.
- mac_enable, mac_only_add, mac_din_a, mac_din_b are registered, so each is one cycle after the accepting handshake.
- in_ready=1 only in BIAS and ACCUM. A handshake is in_valid&&in_ready.
- A cycle with no handshake registers mac_enable=0 (bubble); the accumulator holds its value.
- CLEAR (1 cycle) -> BIAS.
- BIAS: on handshake, register din_a=in_pixel, only_add=1, enable=1; go to ACCUM.
- ACCUM: on each handshake, register din_a=in_pixel, din_b=in_weight, only_add=0, enable=1; tap_cnt++. When tap_cnt==TAPS-1 at the handshake: tap_cnt<=0, go to WAIT.
- WAIT (1 cycle): the MAC absorbs the last beat; registered mac_enable drops to 0 -> CAPT.
- CAPT (1 cycle): register out_data=mac_dout and out_valid=1. Register out_sat=1 iff mac_acc[ACCW-1]==0 and mac_acc[20:15]!=0. Go to OUT.
- OUT: hold out_data and out_sat stable. On out_valid&&out_ready: out_valid<=0 -> CLEAR.
- Latency: out_valid rises 3 cycles after the last tap handshake.
- Minimum window period: TAPS+5 cycles with no bubbles and out_ready=1.
- No input is accepted while a result is pending.
- Windows never overlap; the accumulator is always cleared between windows.
- Boundary, TAPS=1: the first ACCUM handshake goes directly to WAIT.
- Boundary, out_ready already high on entry to OUT: the result leaves in that cycle.

Optional Feature:
- Macro CONV_SEQ_BIAS_EN.
- Defined: the BIAS state and bias beat exist as described above.
- Undefined: CLEAR goes directly to ACCUM. A window is exactly TAPS beats, mac_only_add is tied 0, and the period shrinks by one beat.

Decomposition:
- Package conv_pkg holds:
  - the state enum {CLEAR, BIAS, ACCUM, WAIT, CAPT, OUT};
  - TAPS_DEF=9, DW_DEF=8, ACCW_DEF=22;
  - the overflow field bounds SAT_HI=20 and SAT_LO=15.
- No sub-module; tap_cnt and the FSM stay inline.

Test Plan:
- Bias=1, nine beats pixel=16/weight=16, out_ready=1 -> acc=2560, out_data=10, out_sat=0, out_valid 3 cycles after the 9th beat.
- Bias=1, nine beats pixel=16/weight=-16 -> acc=-2048, out_data=0, out_sat=0.
- Bias=0, nine beats pixel=127/weight=127 -> acc=145161, out_data=55, out_sat=1.
- Random in_valid bubbles during the 16/16 window, then out_ready held low 5 cycles -> out_data=10 stable throughout, in_ready=0 until the handshake, then mac_clr_n=0 for one cycle.
- Reset asserted after 4 taps, then a fresh 16/16 window -> no output for the aborted window; result 10, proving the clear.
- Build without CONV_SEQ_BIAS_EN, nine 16/16 beats -> out_data=9, mac_only_add never 1.
